// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load
// writeback, with one registered write stage and forwarding to both read ports.
module regfile_write_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] rf_wreg,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_regwrite,
  output logic              rf_src,
  input  logic [ADDR_W-1:0] rreg1,
  input  logic [ADDR_W-1:0] rreg2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fsm_state
);

  // Handshake: a transfer happens in a cycle where valid && ready. ready is a
  // combinational function of both valids and the arbiter state; requesters
  // must hold valid/reg/data stable until their transfer and must not derive
  // valid from ready.

  typedef enum logic {
    LAST_MEM = 1'b0,
    LAST_ALU = 1'b1
  } arb_state_t;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  arb_state_t        state_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic              regwrite_q;
  logic              src_q;

  logic              grant_alu;
  logic              grant_mem;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  // A lone requester always wins; on a tie the side not served last wins.
  always_comb begin
    grant_alu = alu_valid && (!mem_valid || (state_q == LAST_MEM));
    grant_mem = mem_valid && (!alu_valid || (state_q == LAST_ALU));
    sel_reg   = grant_mem ? mem_reg  : alu_reg;
    sel_data  = grant_mem ? mem_data : alu_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LAST_MEM;
      wreg_q     <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
      src_q      <= 1'b0;
    end else begin
      regwrite_q <= 1'b0;
      if (grant_alu || grant_mem) begin
        // Zero-register writes still load the stage but never assert regwrite.
        wreg_q     <= sel_reg;
        wdata_q    <= sel_data;
        src_q      <= grant_mem;
        regwrite_q <= (sel_reg != ZERO_IDX);
        state_q    <= grant_mem ? LAST_MEM : LAST_ALU;
      end
    end
  end

  assign alu_ready   = grant_alu;
  assign mem_ready   = grant_mem;
  assign rf_wreg     = wreg_q;
  assign rf_wdata    = wdata_q;
  assign rf_regwrite = regwrite_q;
  assign rf_src      = src_q;
  assign fwd_hit1    = regwrite_q && (wreg_q == rreg1);
  assign fwd_hit2    = regwrite_q && (wreg_q == rreg2);
  assign fwd_data    = wdata_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: drivers push hand-derived write-stage
// records, a negedge monitor pops and compares them one cycle after each transfer.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_reg, mem_reg;
  logic [63:0] alu_data, mem_data;
  logic [4:0]  rf_wreg;
  logic [63:0] rf_wdata;
  logic        rf_regwrite, rf_src;
  logic [4:0]  rreg1, rreg2;
  logic        fwd_hit1, fwd_hit2;
  logic [63:0] fwd_data;
  logic        fsm_state;

  // {regwrite, src, wreg, wdata}
  logic [70:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .rf_wreg(rf_wreg), .rf_wdata(rf_wdata), .rf_regwrite(rf_regwrite), .rf_src(rf_src),
    .rreg1(rreg1), .rreg2(rreg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data(fwd_data), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; returns at the negedge after checking the grants.
  task automatic cyc(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                     input logic mv, input logic [4:0] mr, input logic [63:0] md,
                     input logic ea, input logic em);
    @(posedge clk); #1;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    @(negedge clk);
    check("alu_ready", {70'd0, alu_ready}, {70'd0, ea});
    check("mem_ready", {70'd0, mem_ready}, {70'd0, em});
    if (ea) exp_q.push_back({(ar != 5'd31), 1'b0, ar, ad});
    if (em) exp_q.push_back({(mr != 5'd31), 1'b1, mr, md});
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic check_fwd(input logic h1, input logic h2, input logic [63:0] d);
    check("fwd_hit1", {70'd0, fwd_hit1}, {70'd0, h1});
    check("fwd_hit2", {70'd0, fwd_hit2}, {70'd0, h2});
    if (h1 || h2) check("fwd_data", {7'd0, fwd_data}, {7'd0, d});
  endtask

  // scoreboard monitor
  initial begin
    logic pending;
    logic [70:0] e;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", {rf_regwrite, rf_src, rf_wreg, rf_wdata}, 71'd0);
          end else begin
            e = exp_q.pop_front();
            check("rf_stage", {rf_regwrite, rf_src, rf_wreg, rf_wdata}, e);
          end
        end else begin
          check("rf_regwrite_idle", {70'd0, rf_regwrite}, 71'd0);
        end
        pending = (alu_valid && alu_ready) || (mem_valid && mem_ready);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    rreg1 = '0; rreg2 = '0;

    // 1. reset state, then a tie grants ALU first
    #12;
    check("reset_rf", {rf_regwrite, rf_src, rf_wreg, rf_wdata}, 71'd0);
    check("reset_ready", {69'd0, alu_ready, mem_ready}, 71'd0);
    check("reset_state", {70'd0, fsm_state}, 71'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    cyc(1'b1, 5'd10, 64'h10, 1'b1, 5'd11, 64'h11, 1'b1, 1'b0);
    cyc(1'b0, 5'd0,  64'h0,  1'b1, 5'd11, 64'h11, 1'b0, 1'b1);

    // 2. single ALU requester, then idle; hit on read port 2
    rreg1 = 5'd0; rreg2 = 5'd5;
    cyc(1'b1, 5'd5, 64'hA5, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0);
    idle();
    check_fwd(1'b0, 1'b1, 64'hA5);
    idle();
    check_fwd(1'b0, 1'b0, 64'h0);

    // 3. contention: lone MEM first so the next tie starts from LAST_MEM
    cyc(1'b0, 5'd0, 64'h0,  1'b1, 5'd6, 64'h66, 1'b0, 1'b1);
    cyc(1'b1, 5'd1, 64'h101, 1'b1, 5'd3, 64'h303, 1'b1, 1'b0);
    cyc(1'b1, 5'd2, 64'h202, 1'b1, 5'd3, 64'h303, 1'b0, 1'b1);
    cyc(1'b1, 5'd2, 64'h202, 1'b1, 5'd4, 64'h404, 1'b1, 1'b0);
    cyc(1'b0, 5'd0, 64'h0,   1'b1, 5'd4, 64'h404, 1'b0, 1'b1);
    idle();

    // 4. zero-register drops from both sides; no forwarding hit on reg 31
    rreg1 = 5'd31; rreg2 = 5'd31;
    cyc(1'b0, 5'd0,  64'h0,  1'b1, 5'd31, 64'hFF, 1'b0, 1'b1);
    cyc(1'b1, 5'd31, 64'hEE, 1'b0, 5'd0,  64'h0,  1'b1, 1'b0);
    check_fwd(1'b0, 1'b0, 64'h0);
    idle();
    check_fwd(1'b0, 1'b0, 64'h0);

    // 5. forwarding from an in-flight write
    rreg1 = 5'd7; rreg2 = 5'd8;
    cyc(1'b1, 5'd7, 64'h1234, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0);
    idle();
    check_fwd(1'b1, 1'b0, 64'h1234);
    rreg2 = 5'd7;
    idle();
    check_fwd(1'b0, 1'b0, 64'h0);

    // 6. reset between a transfer and its landing edge
    cyc(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0);
    void'(exp_q.pop_back());
    #2 rst_n = 1'b0;
    alu_valid = 1'b0;
    #1;
    check("midrst_regwrite", {70'd0, rf_regwrite}, 71'd0);
    @(posedge clk); #1;
    check("midrst_rf", {rf_regwrite, rf_src, rf_wreg, rf_wdata}, 71'd0);
    check("midrst_state", {70'd0, fsm_state}, 71'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    cyc(1'b1, 5'd12, 64'hC0, 1'b1, 5'd13, 64'hD0, 1'b1, 1'b0);
    cyc(1'b0, 5'd0,  64'h0,  1'b1, 5'd13, 64'hD0, 1'b0, 1'b1);
    idle();
    idle();

    check("queue_drained", 71'(exp_q.size()), 71'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
